// File: rtl/alu_output_ctrl.sv
// -----------------------------------------------------------------------------
// alu_output_ctrl
//
// Presents a signed ALU result and its flags on 16 LEDs and a 4-digit
// multiplexed seven-segment display (sign, hundreds, tens, ones).
//
// A strobe on i_valid while idle captures the result and flags. The magnitude
// is then converted to BCD with a shift-add-3 (double dabble) sequencer that
// takes one magnitude bit per cycle, and the finished digits are loaded into
// the display registers in a single DONE cycle. Strobes that arrive while a
// conversion is in flight are dropped.
//
// Optional feature (compile-time macro ALU_OUT_BLINK_OVF_EN):
//   When defined, a free-running BLINK_BITS counter blanks all digit enables
//   while the captured overflow flag is set and the counter MSB is high.
//   When undefined, no blink counter exists and overflow is only on o_led[15].
//
// Parameters:
//   N            ALU result width (2..10)
//   REFRESH_BITS display scan counter width
//   BLINK_BITS   overflow blink counter width
//
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous, active-high reset
//   i_alu_Result signed two's-complement ALU result
//   i_ovf_flag   ALU overflow flag
//   i_zero_flag  ALU zero flag
//   i_valid      single-cycle capture strobe
//   o_led        [N-1:0] captured result, [15] overflow, [14] zero, others 0
//   o_seg        active-low segments {g,f,e,d,c,b,a}
//   o_an         active-low digit enables, [0]=ones ... [3]=sign
//   o_busy       high while a conversion is in progress (CONVERT and DONE)
// -----------------------------------------------------------------------------
module alu_output_ctrl #(
  parameter int N            = 8,
  parameter int REFRESH_BITS = 17,
  parameter int BLINK_BITS   = 25
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [N-1:0] i_alu_Result,
  input  logic         i_ovf_flag,
  input  logic         i_zero_flag,
  input  logic         i_valid,
  output logic [15:0]  o_led,
  output logic [6:0]   o_seg,
  output logic [3:0]   o_an,
  output logic         o_busy
);

  // Elaboration-time guard on the legal parameter space.
  if (N < 2 || N > 10 || REFRESH_BITS < 1 || BLINK_BITS < 1) begin : g_param_check
    $error("alu_output_ctrl: illegal parameter value");
  end

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDone
  } state_e;

  // Conversion FSM and capture registers
  state_e         state_q;
  logic           busy_q;
  logic [15:0]    led_q;
  logic           neg_q;
  logic [N-1:0]   shift_q;
  logic [11:0]    bcd_q;
  logic [3:0]     bit_cnt_q;

  // Display registers (only written in DONE)
  logic           sign_q;
  logic [3:0]     hund_q;
  logic [3:0]     tens_q;
  logic [3:0]     ones_q;

  // Scan
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              digit_q;

  // Combinational helpers
  logic [N-1:0]   mag;
  logic [15:0]    led_next;
  logic [11:0]    bcd_adj;
  logic [11:0]    bcd_next;

  // ---------------------------------------------------------------------------
  // Capture-side combinational logic
  // ---------------------------------------------------------------------------

  // Two's-complement negation in N bits maps -2^(N-1) onto itself, which read
  // as unsigned is exactly 2^(N-1); the (N+1)-bit magnitude therefore always
  // has a zero MSB and only the low N bits need to be shifted.
  always_comb begin
    mag = i_alu_Result;
    if (i_alu_Result[N-1]) begin
      mag = ~i_alu_Result + 1'b1;
    end
  end

  always_comb begin
    led_next        = '0;
    led_next[N-1:0] = i_alu_Result;
    led_next[15]    = i_ovf_flag;
    led_next[14]    = i_zero_flag;
  end

  // Double dabble step: add 3 to any BCD digit >= 5, then shift in the next
  // magnitude bit. The 12-bit cast drops the adjusted word's top bit, which is
  // always zero because the hundreds digit never exceeds 5.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = 12'({bcd_adj, shift_q[N-1]});
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      led_q     <= '0;
      neg_q     <= 1'b0;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      sign_q    <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            led_q     <= led_next;
            neg_q     <= i_alu_Result[N-1];
            shift_q   <= mag;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StConvert;
          end
        end
        StConvert: begin
          bcd_q     <= bcd_next;
          shift_q   <= shift_q << 1;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(N - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          sign_q  <= neg_q;
          hund_q  <= bcd_q[11:8];
          tens_q  <= bcd_q[7:4];
          ones_q  <= bcd_q[3:0];
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan: digit index advances when the refresh counter wraps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      if (&refresh_q) begin
        digit_q <= digit_q + 2'd1;
      end
    end
  end

`ifdef ALU_OUT_BLINK_OVF_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Segment decode and digit select
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  always_comb begin
    o_an          = 4'b1111;
    o_an[digit_q] = 1'b0;
    o_seg         = SegBlank;
    unique case (digit_q)
      2'd0: o_seg = seg_code(ones_q);
      2'd1: o_seg = (hund_q == 4'd0 && tens_q == 4'd0) ? SegBlank : seg_code(tens_q);
      2'd2: o_seg = (hund_q == 4'd0) ? SegBlank : seg_code(hund_q);
      2'd3: o_seg = sign_q ? SegDash : SegBlank;
      default: o_seg = SegBlank;
    endcase
`ifdef ALU_OUT_BLINK_OVF_EN
    if (led_q[15] && blink_q[BLINK_BITS-1]) begin
      o_an = 4'b1111;
    end
`endif
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule
